ex: RTL and testbench
=====================

# ex

Execute stage of the five-stage MIPS pipeline, directly downstream of ID. Latches `id_to_ex_bus` into the EX pipeline register and evaluates the ALU. It also hosts the HI/LO registers, a single-cycle multiplier and a 32-iteration restoring divider that holds the pipeline through `stallreq_for_ex`. It drives the data SRAM request and produces `ex_to_mem_bus` plus the `ex_to_id_bus` forwarding copy.

## Interface
- No parameters; widths come from `lib/defines.vh` (`ID_TO_EX_WD`=159, `EX_TO_MEM_WD`=76, `StallBus`=6).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in `StallBus`: per-stage stall vector; bit 2 = EX input register, bit 3 = MEM.
- `id_to_ex_bus` in 159: {pc, inst, alu_op[11:0], sel_alu_src1[2:0], sel_alu_src2[3:0], data_ram_en, data_ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rdata1, rdata2}, MSB first.
- `ex_to_mem_bus` out 76: {pc, data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result}.
- `ex_to_id_bus` out 76: identical copy of `ex_to_mem_bus`, used for ID forwarding.
- `stall_en` out 1: load in EX (`data_ram_en & sel_rf_res`), used by ID for load-use stall.
- `stallreq_for_ex` out 1: divider busy.
- `data_sram_en` out 1, `data_sram_wen` out 4, `data_sram_addr` out 32, `data_sram_wdata` out 32.

## Operation
- Input register update on `clk`, in priority order:
  - `rst`: clear to 0.
  - `stall[2]`=Stop and `stall[3]`=NoStop: load 0 (bubble).
  - `stall[2]`=NoStop: load `id_to_ex_bus`.
  - Otherwise: hold.
- src1: `rdata1` if sel1[0]; pc if sel1[1]; {27'b0, inst[10:6]} if sel1[2].
- src2: `rdata2` if sel2[0]; sign-extended imm16 if sel2[1]; 32'd8 if sel2[2]; zero-extended imm16 if sel2[3].
- alu_op is one-hot, MSB first: add, sub, slt (signed), sltu, and, nor, or, xor, sll, srl, sra, lui.
  - All arithmetic wraps modulo 2^32; no overflow trap.
  - Shifts move src2 by src1[4:0].
  - lui = {src2[15:0], 16'b0}.
- EX decodes mult/multu/div/divu/mfhi/mflo/mthi/mtlo itself from `inst` (opcode 0, funct 18/19/1A/1B/10/12/11/13).
  - mfhi/mflo: ex_result = HI/LO.
  - mthi/mtlo: write `rdata1`.
- mult/multu: 64-bit product of `rdata1`, `rdata2`; {HI,LO} written at the end of the cycle the instruction occupies EX with no stall.
- Divider FSM: IDLE → RUN → DONE → IDLE.
  - IDLE, div/divu present: capture operand magnitudes and sign flags, counter=0, go RUN.
  - RUN: one restoring shift-subtract step per cycle; after the 32nd step go DONE.
  - DONE: apply signs, LO=quotient, HI=remainder (remainder takes the dividend's sign), write at that edge, go IDLE.
  - Divisor 0: runs the full sequence; result LO=32'hFFFF_FFFF, HI=dividend.
- `stallreq_for_ex` = (IDLE & div present) | RUN. It is low in DONE.
- Data SRAM:
  - `data_sram_en`=data_ram_en.
  - `data_sram_wen`=data_ram_wen.
  - `data_sram_addr`=ex_result.
  - `data_sram_wdata`=rdata2.

## Timing
- Reset values:
  - All bus outputs, data SRAM outputs, `stall_en` and `stallreq_for_ex` are 0.
  - HI=LO=0; FSM in IDLE.
- ALU, SRAM request and forwarding outputs are combinational from the EX register: zero added latency. MEM sees the result one edge later.
- Divide entering EX at cycle T:
  - `stallreq_for_ex` is high T..T+32 and low at T+33.
  - HI/LO are updated at the end of T+33.
  - The next instruction enters EX at T+34.
- mfhi immediately after div or mult reads the updated value; no forwarding is needed.
- Bubble or hold while the FSM is RUN: the FSM continues running.
- `rst` mid-divide: FSM returns to IDLE, HI/LO are cleared, no partial result is written.
- Instruction word 0 (sll $0) produces a harmless rf_we to register 0; this is permitted.

## Test plan
- ori: rdata1=0x0000_1200, imm=0x0034 → ex_result=0x0000_1234; rf_we=1; rf_waddr=rt.
- jal at pc=0xBFC0_0010 → ex_result=0xBFC0_0018, rf_waddr=31.
- sw: rdata1=0x100, imm=0xFFFC, rdata2=0xDEAD_BEEF → sram_en=1, wen=4'hF, addr=0xFC, wdata=0xDEAD_BEEF. lw → `stall_en`=1.
- div of −7 by 2 → stall for exactly 33 cycles, then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. Subsequent mflo returns 0xFFFF_FFFD.
- multu 0xFFFF_FFFF×2 → HI=1, LO=0xFFFF_FFFE. divu by 0 of 5 → LO=0xFFFF_FFFF, HI=5.
- `stall[2]`=1 with `stall[3]`=0 → `ex_to_mem_bus`=0 next cycle. Assert `rst` at RUN step 10 → `stallreq_for_ex`=0 next cycle, HI/LO=0.

Source files
------------

// File: rtl/ex.sv
// MIPS execute stage: EX pipeline register, ALU, HI/LO with 1-cycle multiplier and 32-step restoring divider.
// Latency: ALU/SRAM/forwarding outputs are combinational from the EX register; a divide occupies EX for 34 cycles.
// Backpressure: stallreq_for_ex holds upstream while the divider is busy; stall[2]/stall[3] hold or bubble the EX register.
module ex (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [75:0]  ex_to_id_bus,
    output logic         stall_en,
    output logic         stallreq_for_ex,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

    id_ex_t      id_ex_q, id_ex_d;
    div_state_e  div_state_q, div_state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dvs_zero_q, dvs_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] src1, src2, imm_sext, imm_zext, sra_res, alu_res, ex_result;
    logic [4:0]  shamt;
    logic        is_special;
    logic        inst_mult, inst_multu, inst_div, inst_divu;
    logic        inst_mfhi, inst_mflo, inst_mthi, inst_mtlo, div_start;
    logic        a_neg, b_neg;
    logic [63:0] prod_s, prod_u;
    logic [32:0] shifted, trial;
    logic [31:0] div_quo_res, div_rem_res;
    logic        unused_bits;

    assign unused_bits = ^{stall[5:4], stall[1:0], id_ex_q.inst[25:16]};

    always_comb begin
        id_ex_d = id_ex_q;
        if (stall[2] && !stall[3]) begin
            id_ex_d = '0;
        end else if (!stall[2]) begin
            id_ex_d = id_ex_t'(id_to_ex_bus);
        end
    end

    assign imm_sext = {{16{id_ex_q.inst[15]}}, id_ex_q.inst[15:0]};
    assign imm_zext = {16'b0, id_ex_q.inst[15:0]};

    assign src1 = ({32{id_ex_q.sel_src1[0]}} & id_ex_q.rdata1)
                | ({32{id_ex_q.sel_src1[1]}} & id_ex_q.pc)
                | ({32{id_ex_q.sel_src1[2]}} & {27'b0, id_ex_q.inst[10:6]});
    assign src2 = ({32{id_ex_q.sel_src2[0]}} & id_ex_q.rdata2)
                | ({32{id_ex_q.sel_src2[1]}} & imm_sext)
                | ({32{id_ex_q.sel_src2[2]}} & 32'd8)
                | ({32{id_ex_q.sel_src2[3]}} & imm_zext);

    assign shamt   = src1[4:0];
    assign sra_res = $signed(src2) >>> shamt;

    // alu_op is one-hot, so OR-combining the selected terms is a plain mux
    always_comb begin
        alu_res = '0;
        if (id_ex_q.alu_op[11]) alu_res = alu_res | (src1 + src2);
        if (id_ex_q.alu_op[10]) alu_res = alu_res | (src1 - src2);
        if (id_ex_q.alu_op[9])  alu_res = alu_res | {31'b0, $signed(src1) < $signed(src2)};
        if (id_ex_q.alu_op[8])  alu_res = alu_res | {31'b0, src1 < src2};
        if (id_ex_q.alu_op[7])  alu_res = alu_res | (src1 & src2);
        if (id_ex_q.alu_op[6])  alu_res = alu_res | ~(src1 | src2);
        if (id_ex_q.alu_op[5])  alu_res = alu_res | (src1 | src2);
        if (id_ex_q.alu_op[4])  alu_res = alu_res | (src1 ^ src2);
        if (id_ex_q.alu_op[3])  alu_res = alu_res | (src2 << shamt);
        if (id_ex_q.alu_op[2])  alu_res = alu_res | (src2 >> shamt);
        if (id_ex_q.alu_op[1])  alu_res = alu_res | sra_res;
        if (id_ex_q.alu_op[0])  alu_res = alu_res | {src2[15:0], 16'b0};
    end

    assign is_special = (id_ex_q.inst[31:26] == 6'h00);
    assign inst_mult  = is_special && (id_ex_q.inst[5:0] == 6'h18);
    assign inst_multu = is_special && (id_ex_q.inst[5:0] == 6'h19);
    assign inst_div   = is_special && (id_ex_q.inst[5:0] == 6'h1A);
    assign inst_divu  = is_special && (id_ex_q.inst[5:0] == 6'h1B);
    assign inst_mfhi  = is_special && (id_ex_q.inst[5:0] == 6'h10);
    assign inst_mthi  = is_special && (id_ex_q.inst[5:0] == 6'h11);
    assign inst_mflo  = is_special && (id_ex_q.inst[5:0] == 6'h12);
    assign inst_mtlo  = is_special && (id_ex_q.inst[5:0] == 6'h13);
    assign div_start  = inst_div || inst_divu;

    // Low 64 bits of the sign-extended product equal the signed product
    assign prod_u = {32'b0, id_ex_q.rdata1} * {32'b0, id_ex_q.rdata2};
    assign prod_s = {{32{id_ex_q.rdata1[31]}}, id_ex_q.rdata1} * {{32{id_ex_q.rdata2[31]}}, id_ex_q.rdata2};

    assign a_neg   = inst_div && id_ex_q.rdata1[31];
    assign b_neg   = inst_div && id_ex_q.rdata2[31];
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        div_state_d = div_state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dvs_zero_d  = dvs_zero_q;
        case (div_state_q)
            DIV_IDLE: begin
                if (div_start) begin
                    quo_d       = a_neg ? -id_ex_q.rdata1 : id_ex_q.rdata1;
                    dvs_d       = b_neg ? -id_ex_q.rdata2 : id_ex_q.rdata2;
                    rem_d       = '0;
                    cnt_d       = '0;
                    neg_quo_d   = a_neg ^ b_neg;
                    neg_rem_d   = a_neg;
                    dvs_zero_d  = (id_ex_q.rdata2 == 32'h0);
                    div_state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                // Quotient register doubles as the dividend shift-out register
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    div_state_d = DIV_DONE;
                end
            end
            DIV_DONE: div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
    end

    assign div_quo_res = dvs_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q);
    assign div_rem_res = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_state_q == DIV_DONE) begin
            hi_d = div_rem_res;
            lo_d = div_quo_res;
        end else if (!stall[3]) begin
            if (inst_mult) begin
                {hi_d, lo_d} = prod_s;
            end else if (inst_multu) begin
                {hi_d, lo_d} = prod_u;
            end else if (inst_mthi) begin
                hi_d = id_ex_q.rdata1;
            end else if (inst_mtlo) begin
                lo_d = id_ex_q.rdata1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q     <= '0;
            div_state_q <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dvs_zero_q  <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            id_ex_q     <= id_ex_d;
            div_state_q <= div_state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dvs_zero_q  <= dvs_zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign ex_result = inst_mfhi ? hi_q : (inst_mflo ? lo_q : alu_res);

    assign stallreq_for_ex = ((div_state_q == DIV_IDLE) && div_start) || (div_state_q == DIV_RUN);
    assign stall_en        = id_ex_q.ram_en & id_ex_q.sel_rf_res;

    assign ex_to_mem_bus = {id_ex_q.pc, id_ex_q.ram_en, id_ex_q.ram_wen, id_ex_q.sel_rf_res,
                            id_ex_q.rf_we, id_ex_q.rf_waddr, ex_result};
    assign ex_to_id_bus  = ex_to_mem_bus;

    assign data_sram_en    = id_ex_q.ram_en;
    assign data_sram_wen   = id_ex_q.ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = id_ex_q.rdata2;

endmodule

// File: tb/tb_ex.sv
// Bench for the execute stage: directed table, randomized ALU/mult/div against a reference model, stall/reset sequences.
module tb_ex;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_t;

    typedef struct {
        id_t         in;
        logic [31:0] res;
        string       nm;
    } vec_t;

    localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100;
    localparam logic [11:0] OP_NOR = 12'h040, OP_OR = 12'h020, OP_SLL = 12'h008, OP_SRA = 12'h002;
    localparam logic [11:0] OP_LUI = 12'h001;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus, ex_to_id_bus;
    logic         stall_en, stallreq_for_ex, data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id_bus(ex_to_id_bus),
        .stall_en(stall_en), .stallreq_for_ex(stallreq_for_ex),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic id_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
                               input logic [2:0] s1, input logic [3:0] s2, input logic ren,
                               input logic [3:0] wen, input logic we, input logic [4:0] wa,
                               input logic srr, input logic [31:0] r1, input logic [31:0] r2);
        id_t v;
        v.pc = pc; v.inst = inst; v.alu_op = op; v.sel_src1 = s1; v.sel_src2 = s2;
        v.ram_en = ren; v.ram_wen = wen; v.rf_we = we; v.rf_waddr = wa; v.sel_rf_res = srr;
        v.rdata1 = r1; v.rdata2 = r2;
        return v;
    endfunction

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            0:  return x + y;
            1:  return x - y;
            2:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3:  return (x < y) ? 32'd1 : 32'd0;
            4:  return x & y;
            5:  return ~(x | y);
            6:  return x | y;
            7:  return x ^ y;
            8:  return y << x[4:0];
            9:  return y >> x[4:0];
            10: return $signed(y) >>> x[4:0];
            11: return {y[15:0], 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        if (b == 32'h0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    task automatic apply_check(input id_t v, input logic [31:0] res, input string nm);
        logic [75:0] exp_bus;
        id_to_ex_bus = v;
        stall = '0;
        tick();
        exp_bus = {v.pc, v.ram_en, v.ram_wen, v.sel_rf_res, v.rf_we, v.rf_waddr, res};
        chk({nm, " mem_bus"}, ex_to_mem_bus, exp_bus);
        chk({nm, " id_bus"}, ex_to_id_bus, exp_bus);
        chk({nm, " sram"}, {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            {v.ram_en, v.ram_wen, res, v.rdata2});
        chk({nm, " stall_en"}, stall_en, v.ram_en & v.sel_rf_res);
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        id_to_ex_bus = mk(32'h0, 32'h0000_1010, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0);
        stall = '0;
        tick();
        hi = ex_to_mem_bus[31:0];
        id_to_ex_bus = mk(32'h0, 32'h0000_1012, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0);
        tick();
        lo = ex_to_mem_bus[31:0];
    endtask

    task automatic do_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string nm);
        logic [63:0] p;
        logic [31:0] hi, lo;
        p = sgn ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'h0, a} * {32'h0, b};
        id_to_ex_bus = mk(32'h0, sgn ? 32'h0022_0018 : 32'h0022_0019, 12'h0, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
        stall = '0;
        tick();
        read_hilo(hi, lo);
        chk({nm, " hi"}, hi, p[63:32]);
        chk({nm, " lo"}, lo, p[31:0]);
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string nm);
        int cyc;
        logic [31:0] hi, lo, ehi, elo;
        id_to_ex_bus = mk(32'h0, sgn ? 32'h0022_001A : 32'h0022_001B, 12'h0, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
        stall = '0;
        tick();
        cyc = 0;
        while (stallreq_for_ex && cyc < 100) begin
            cyc++;
            stall = 6'b001111;
            tick();
        end
        stall = '0;
        chk({nm, " stall cycles"}, cyc, 33);
        div_ref(sgn, a, b, ehi, elo);
        read_hilo(hi, lo);
        chk({nm, " lo"}, lo, elo);
        chk({nm, " hi"}, hi, ehi);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        logic [31:0] hi, lo, r, a, b, pc, inst, s1v, s2v;
        logic [75:0] held;
        int op, k1, k2, cyc;

        tbl[0] = '{mk(32'hBFC0_0000, 32'h3422_0034, OP_OR,  3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd2,  1'b0, 32'h0000_1200, 32'h5555_5555), 32'h0000_1234, "ori"};
        tbl[1] = '{mk(32'hBFC0_0010, 32'h0FF0_0100, OP_ADD, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0), 32'hBFC0_0018, "jal"};
        tbl[2] = '{mk(32'hBFC0_0020, 32'hAC23_FFFC, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,  1'b0, 32'h0000_0100, 32'hDEAD_BEEF), 32'h0000_00FC, "sw"};
        tbl[3] = '{mk(32'hBFC0_0024, 32'h8C23_FFFC, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd3,  1'b1, 32'h0000_1000, 32'h0), 32'h0000_0FFC, "lw"};
        tbl[4] = '{mk(32'hBFC0_0028, 32'h3C04_1234, OP_LUI, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'h0, 32'h0), 32'h1234_0000, "lui"};
        tbl[5] = '{mk(32'hBFC0_002C, 32'h0006_2900, OP_SLL, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'h0, 32'h0000_00F1), 32'h0000_0F10, "sll"};
        tbl[6] = '{mk(32'hBFC0_0030, 32'h0022_182A, OP_SLT, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,  1'b0, 32'hFFFF_FFFF, 32'h1), 32'h1, "slt"};
        tbl[7] = '{mk(32'hBFC0_0034, 32'h0022_182B, OP_SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'h1), 32'h0, "sltu"};
        tbl[8] = '{mk(32'hBFC0_0038, 32'h0006_2903, OP_SRA, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'h0, 32'h8000_0000), 32'hF800_0000, "sra"};
        tbl[9] = '{mk(32'hBFC0_003C, 32'h0022_1823, OP_SUB, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,  1'b0, 32'h0, 32'h1), 32'hFFFF_FFFF, "subu wrap"};

        rst = 1'b1;
        stall = '0;
        id_to_ex_bus = '0;
        tick();
        tick();
        chk("reset mem_bus", ex_to_mem_bus, 76'h0);
        chk("reset id_bus", ex_to_id_bus, 76'h0);
        chk("reset sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 69'h0);
        chk("reset stall flags", {stall_en, stallreq_for_ex}, 2'b00);
        rst = 1'b0;
        read_hilo(hi, lo);
        chk("reset hilo", {hi, lo}, 64'h0);

        foreach (tbl[i]) apply_check(tbl[i].in, tbl[i].res, tbl[i].nm);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 11);
            k1 = $urandom_range(0, 2);
            k2 = $urandom_range(0, 3);
            r  = $urandom;
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            pc = $urandom;
            inst = {6'($urandom_range(1, 63)), r[25:0]};
            s1v = (k1 == 0) ? a : (k1 == 1) ? pc : {27'h0, inst[10:6]};
            s2v = (k2 == 0) ? b : (k2 == 1) ? {{16{inst[15]}}, inst[15:0]} :
                  (k2 == 2) ? 32'd8 : {16'h0, inst[15:0]};
            apply_check(mk(pc, inst, 12'h800 >> op, 3'b001 << k1, 4'b0001 << k2, r[31], r[30:27],
                           r[26], r[4:0], r[5], a, b),
                        alu_ref(op, s1v, s2v), $sformatf("rand alu op%0d", op));
        end

        do_mult(1'b0, 32'hFFFF_FFFF, 32'h2, "multu max*2");
        do_mult(1'b1, 32'hFFFF_FFFD, 32'h5, "mult -3*5");
        for (int i = 0; i < 4; i++) do_mult(i[0], $urandom, $urandom, "rand mult");

        do_div(1'b1, 32'hFFFF_FFF9, 32'h2, "div -7/2");
        do_div(1'b0, 32'h5, 32'h0, "divu 5/0");
        do_div(1'b1, 32'hFFFF_FFF0, 32'h0, "div -16/0");
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i < 3) ? 32'($urandom_range(1, 20)) : $urandom;
            do_div(i[0], a, b, "rand div");
        end

        apply_check(mk(32'h0, 32'h0020_0011, 12'h0, 3'b001, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h1111_2222, 32'h0), 32'h0, "mthi");
        apply_check(mk(32'h0, 32'h0020_0013, 12'h0, 3'b001, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h3333_4444, 32'h0), 32'h0, "mtlo");
        read_hilo(hi, lo);
        chk("mthi/mtlo", {hi, lo}, 64'h1111_2222_3333_4444);

        apply_check(tbl[0].in, tbl[0].res, "ori before hold");
        held = ex_to_mem_bus;
        id_to_ex_bus = tbl[1].in;
        stall = 6'b001100;
        tick();
        chk("hold keeps bus", ex_to_mem_bus, {tbl[0].in.pc, 5'h0, 1'b0, 1'b1, 5'd2, 32'h0000_1234});
        stall = 6'b000100;
        tick();
        chk("bubble clears bus", ex_to_mem_bus, 76'h0);
        chk("bubble after hold differs", (held == 76'h0), 1'b0);

        id_to_ex_bus = mk(32'h0, 32'h0022_001B, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7);
        stall = '0;
        tick();
        stall = 6'b001111;
        tick();
        stall = 6'b000100;
        id_to_ex_bus = '0;
        tick();
        chk("bubble during run stallreq", stallreq_for_ex, 1'b1);
        chk("bubble during run bus", ex_to_mem_bus, 76'h0);
        cyc = 0;
        while (stallreq_for_ex && cyc < 100) begin
            cyc++;
            stall = 6'b001111;
            tick();
        end
        stall = '0;
        chk("bubble during run remaining", cyc, 31);
        read_hilo(hi, lo);
        chk("bubble during run hilo", {hi, lo}, {32'd2, 32'd14});

        id_to_ex_bus = mk(32'h0, 32'h0022_001B, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd1000, 32'd3);
        stall = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            stall = 6'b001111;
            tick();
        end
        chk("run step 10 stallreq", stallreq_for_ex, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid-div stallreq", stallreq_for_ex, 1'b0);
        chk("rst mid-div bus", ex_to_mem_bus, 76'h0);
        read_hilo(hi, lo);
        chk("rst mid-div hilo", {hi, lo}, 64'h0);
        do_div(1'b0, 32'd1000, 32'd3, "div after rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
